// File: rtl/seg_pkg.sv
// seg_pkg: segment patterns (bit order g..a) and scan FSM states for the 7-segment scanner
package seg_pkg;
    localparam logic [6:0] SEG_0   = 7'b0111111;
    localparam logic [6:0] SEG_1   = 7'b0000110;
    localparam logic [6:0] SEG_2   = 7'b1011011;
    localparam logic [6:0] SEG_3   = 7'b1001111;
    localparam logic [6:0] SEG_4   = 7'b1100110;
    localparam logic [6:0] SEG_5   = 7'b1101101;
    localparam logic [6:0] SEG_6   = 7'b1111101;
    localparam logic [6:0] SEG_7   = 7'b0000111;
    localparam logic [6:0] SEG_8   = 7'b1111111;
    localparam logic [6:0] SEG_9   = 7'b1101111;
    localparam logic [6:0] SEG_OFF = 7'b0000000;

    typedef enum logic {IDLE, SCAN} state_t;
endpackage

// File: rtl/seg_bcd_lut.sv
// seg_bcd_lut: combinational BCD nibble to segment pattern, non-decimal codes dark
module seg_bcd_lut
    import seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);
    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_OFF;
        endcase
    end
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed 7-segment scanner with tear-free double buffer, blanking and leading-zero suppression
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NDIG      = 4,
    parameter int DIV       = 1000,
    parameter int BLANK_CYC = 2,
    parameter int LZB       = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [4*NDIG-1:0] wr_data,
    input  logic [NDIG-1:0]   wr_dp,
    output logic [6:0]        seg,
    output logic              dp,
    output logic [NDIG-1:0]   an,
    output logic              frame_start
);
    localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
    localparam int DW = $clog2(NDIG);

    state_t            state, state_nx;
    logic [CW-1:0]     cnt, cnt_nx;
    logic [DW-1:0]     dig, dig_nx;
    logic [4*NDIG-1:0] pend_data, act_data, act_data_nx;
    logic [NDIG-1:0]   pend_dp, act_dp, act_dp_nx;
    logic              pend_valid, act_loaded, load_act, wr_acc, last, blank;
    logic [NDIG-1:0]   nz, an_nx;
    logic [6:0]        lut_seg;

    assign wr_ready = !pend_valid;
    assign wr_acc   = wr_valid && wr_ready;
    assign last     = cnt == CW'(DIV - 1);

    always_comb begin
        state_nx = state;
        cnt_nx   = '0;
        dig_nx   = '0;
        load_act = 1'b0;
        if (state == IDLE) begin
            state_nx = (en && (act_loaded || pend_valid)) ? SCAN : IDLE;
            load_act = en && pend_valid;
        end else if (!en) begin
            state_nx = IDLE;
        end else begin
            cnt_nx   = last ? '0 : cnt + 1'b1;
            dig_nx   = !last ? dig : (dig == DW'(NDIG - 1)) ? '0 : dig + 1'b1;
            load_act = last && dig == DW'(NDIG - 1) && pend_valid;
        end
    end

    assign act_data_nx = load_act ? pend_data : act_data;
    assign act_dp_nx   = load_act ? pend_dp : act_dp;

    // nz[k]: some digit at or above k is non-zero
    always_comb begin
        logic acc;
        acc = 1'b0;
        nz  = '0;
        for (int k = NDIG - 1; k >= 0; k--) begin
            acc   = acc | (|act_data_nx[4*k +: 4]);
            nz[k] = acc;
        end
    end

    seg_bcd_lut u_lut (
        .bcd(act_data_nx[4*dig_nx +: 4]),
        .seg(lut_seg)
    );

    // Outputs are registered from next-state values so they line up with the state they describe
    assign blank = LZB != 0 && dig_nx != '0 && !nz[dig_nx];
    assign an_nx = (state_nx == SCAN && cnt_nx >= CW'(BLANK_CYC)) ? NDIG'(1) << dig_nx : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            dig         <= '0;
            pend_data   <= '0;
            pend_dp     <= '0;
            pend_valid  <= 1'b0;
            act_data    <= '0;
            act_dp      <= '0;
            act_loaded  <= 1'b0;
            an          <= '0;
            seg         <= SEG_OFF;
            dp          <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            dig         <= dig_nx;
            pend_data   <= wr_acc ? wr_data : pend_data;
            pend_dp     <= wr_acc ? wr_dp : pend_dp;
            pend_valid  <= wr_acc || (pend_valid && !load_act);
            act_data    <= act_data_nx;
            act_dp      <= act_dp_nx;
            act_loaded  <= act_loaded || load_act;
            an          <= an_nx;
            seg         <= (an_nx != '0 && !blank) ? lut_seg : SEG_OFF;
            dp          <= an_nx != '0 && act_dp_nx[dig_nx];
            frame_start <= state_nx == SCAN && cnt_nx == '0 && dig_nx == '0;
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed and random scan checks of two scanners (LZB off/on) against a frame-time model
module tb_seg_scan_ctrl;
    localparam int NDIG  = 4;
    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = NDIG * DIV;

    logic        clk = 0, rst_n = 0, en = 0, wr_valid = 0;
    logic [15:0] wr_data = '0;
    logic [3:0]  wr_dp = '0;
    logic [6:0]  seg0, seg1;
    logic        dp0, dp1, fs0, fs1, rdy0, rdy1;
    logic [3:0]  an0, an1;
    int          n_checks = 0, n_errs = 0;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.NDIG(NDIG), .DIV(DIV), .BLANK_CYC(BLANK), .LZB(0)) u_plain (
        .clk(clk), .rst_n(rst_n), .en(en), .wr_valid(wr_valid), .wr_ready(rdy0),
        .wr_data(wr_data), .wr_dp(wr_dp), .seg(seg0), .dp(dp0), .an(an0), .frame_start(fs0)
    );

    seg_scan_ctrl #(.NDIG(NDIG), .DIV(DIV), .BLANK_CYC(BLANK), .LZB(1)) u_lzb (
        .clk(clk), .rst_n(rst_n), .en(en), .wr_valid(wr_valid), .wr_ready(rdy1),
        .wr_data(wr_data), .wr_dp(wr_dp), .seg(seg1), .dp(dp1), .an(an1), .frame_start(fs1)
    );

    // Model: scanning flag plus cycles elapsed since the scan started
    bit          m_scan, m_pv, m_loaded;
    int          m_t;
    logic [15:0] m_pend, m_act;
    logic [3:0]  m_pend_dp, m_act_dp;
    logic [6:0]  digits [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                                 7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};
    logic [6:0]  got0 [NDIG];
    logic [6:0]  got1 [NDIG];

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int cur_dig();
        return (m_t / DIV) % NDIG;
    endfunction

    function automatic logic [3:0] exp_an();
        if (!m_scan || (m_t % DIV) < BLANK) return 4'd0;
        return 4'(1 << cur_dig());
    endfunction

    function automatic logic [6:0] exp_seg(bit lzb);
        logic [15:0] hi;
        if (exp_an() == 0) return 7'd0;
        hi = m_act >> (4 * cur_dig());
        if (lzb && cur_dig() > 0 && hi == 0) return 7'd0;
        return hi[3:0] < 10 ? digits[hi[3:0]] : 7'd0;
    endfunction

    task automatic model_reset();
        m_scan = 0; m_pv = 0; m_loaded = 0; m_t = 0;
        m_pend = '0; m_act = '0; m_pend_dp = '0; m_act_dp = '0;
    endtask

    task automatic model_load();
        m_act = m_pend; m_act_dp = m_pend_dp; m_pv = 0; m_loaded = 1;
    endtask

    task automatic model_edge();
        bit acc;
        acc = wr_valid && !m_pv;
        if (!m_scan) begin
            if (en && (m_loaded || m_pv)) begin
                m_scan = 1;
                m_t = 0;
                if (m_pv) model_load();
            end
        end else if (!en) begin
            m_scan = 0;
        end else begin
            m_t++;
            if (m_t % FRAME == 0 && m_pv) model_load();
        end
        if (acc) begin
            m_pend = wr_data; m_pend_dp = wr_dp; m_pv = 1;
        end
    endtask

    task automatic check_all();
        logic exp_dp;
        exp_dp = exp_an() != 0 && m_act_dp[cur_dig()];
        check("an", an0, exp_an());
        check("an_lzb", an1, exp_an());
        check("seg", seg0, exp_seg(0));
        check("seg_lzb", seg1, exp_seg(1));
        check("dp", dp0, exp_dp);
        check("dp_lzb", dp1, exp_dp);
        check("frame_start", fs0, m_scan && m_t % FRAME == 0);
        check("frame_start_lzb", fs1, m_scan && m_t % FRAME == 0);
        check("wr_ready", rdy0, !m_pv);
        check("wr_ready_lzb", rdy1, !m_pv);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic write(logic [15:0] d, logic [3:0] p);
        bit acc;
        wr_valid = 1; wr_data = d; wr_dp = p;
        for (int i = 0; i < 200; i++) begin
            acc = !m_pv;
            step();
            if (acc) begin
                wr_valid = 0;
                return;
            end
        end
        wr_valid = 0;
        check("write_timeout_ready", rdy0, 1);
    endtask

    task automatic capture();
        for (int k = 0; k < NDIG; k++) begin
            got0[k] = 7'h7f;
            got1[k] = 7'h7f;
        end
        repeat (FRAME) begin
            step();
            for (int k = 0; k < NDIG; k++) begin
                if (an0 == 4'(1 << k)) got0[k] = seg0;
                if (an1 == 4'(1 << k)) got1[k] = seg1;
            end
        end
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check_all();
        rst_n = 1;
        repeat (100) step();

        en = 1;
        write(16'h1234, 4'b0100);
        repeat (2) step();
        capture();
        check("basic_d0", got0[0], 7'b1100110);
        check("basic_d1", got0[1], 7'b1001111);
        check("basic_d2", got0[2], 7'b1011011);
        check("basic_d3", got0[3], 7'b0000110);

        repeat (10) step();
        write(16'h5678, 4'b0001);
        repeat (2 * FRAME) step();

        write(16'h1111, 4'b0000);
        write(16'h2222, 4'b1111);
        repeat (2 * FRAME) step();

        write(16'h0070, 4'b0000);
        repeat (FRAME + 4) step();
        capture();
        check("lzb70_d3", got1[3], 7'd0);
        check("lzb70_d2", got1[2], 7'd0);
        check("lzb70_d1", got1[1], 7'b0000111);
        check("lzb70_d0", got1[0], 7'b0111111);
        check("plain70_d3", got0[3], 7'b0111111);

        write(16'h0000, 4'b0010);
        repeat (FRAME + 4) step();
        capture();
        check("lzb00_d1", got1[1], 7'd0);
        check("lzb00_d0", got1[0], 7'b0111111);

        for (int i = 0; i < 100 && !(m_scan && cur_dig() == 2 && m_t % DIV >= BLANK); i++) step();
        en = 0;
        step();
        check("en_off_an", an0, 4'd0);
        repeat (5) step();
        en = 1;
        repeat (FRAME) step();

        repeat (3 * DIV + 3) step();
        #2 rst_n = 0;
        #1;
        check("async_an", an0, 4'd0);
        check("async_an_lzb", an1, 4'd0);
        check("async_seg", seg0, 7'd0);
        check("async_ready", rdy0, 1);
        model_reset();
        @(negedge clk);
        check_all();
        rst_n = 1;
        repeat (10) step();

        for (int i = 0; i < 3000; i++) begin
            en = $urandom_range(0, 99) < 95;
            wr_valid = $urandom_range(0, 7) == 0;
            wr_data = 16'($urandom) >> (4 * $urandom_range(0, 4));
            wr_dp = 4'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
